// File: rtl/elliptic_curve_structs.sv
// Shared types and constants for the ECDSA engine front end.
package elliptic_curve_structs;

  localparam int ECDSA_NUM_REQ = 2;
  localparam int ECDSA_HASH_W  = 256;

  typedef struct packed {
    logic [ECDSA_HASH_W-1:0] r;
    logic [ECDSA_HASH_W-1:0] s;
  } signature_t;

  // Turn a requester index into the matching one-hot requester vector.
  function automatic logic [ECDSA_NUM_REQ-1:0] req_onehot(input logic idx);
    logic [ECDSA_NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ecdsa_rr_picker.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to
// the requester that was not served last.
module ecdsa_rr_picker
  import elliptic_curve_structs::*;
(
  input  logic [ECDSA_NUM_REQ-1:0] req,
  input  logic                     last_grant,
  output logic [ECDSA_NUM_REQ-1:0] grant
);

  // Pick the winner purely from the current requests and the previous owner.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/ecdsa_engine_arbiter.sv
// Shares one ECDSA engine between a signer (index 0) and a verifier
// (index 1). One transaction at a time: accept, start the engine, wait for
// completion or give up after TIMEOUT_CYCLES, then answer the owner.
module ecdsa_engine_arbiter
  import elliptic_curve_structs::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                        clk,
  input  logic                                        master_reset,
  input  logic [ECDSA_NUM_REQ-1:0]                    req_valid,
  input  logic [ECDSA_NUM_REQ-1:0][ECDSA_HASH_W-1:0]  req_msg,
  output logic [ECDSA_NUM_REQ-1:0]                    req_ready,
  output logic [ECDSA_NUM_REQ-1:0]                    resp_valid,
  output signature_t                                  resp_result,
  output logic                                        resp_error,
  output logic                                        eng_start,
  output logic [ECDSA_HASH_W-1:0]                     eng_msg,
  input  logic                                        eng_done,
  input  signature_t                                  eng_result,
  output logic                                        eng_abort,
  output logic                                        busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    RESP,
    ABORT
  } state_t;

  // Last count value seen in BUSY before the engine is declared hung.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic                     owner;
  logic                     last_grant;
  logic [15:0]              counter;
  logic [ECDSA_NUM_REQ-1:0] grant;
  logic                     win_idx;

  ecdsa_rr_picker u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign win_idx = grant[1];

  // Acceptance is offered only while idle and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !master_reset) begin
      req_ready = grant;
    end
  end

  // Transaction FSM; every output except req_ready is a register that is
  // loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (master_reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      counter     <= '0;
      eng_msg     <= '0;
      eng_start   <= 1'b0;
      eng_abort   <= 1'b0;
      resp_valid  <= '0;
      resp_error  <= 1'b0;
      resp_result <= '0;
      busy        <= 1'b0;
    end else begin
      eng_start   <= 1'b0;
      eng_abort   <= 1'b0;
      resp_valid  <= '0;
      resp_error  <= 1'b0;
      resp_result <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= win_idx;
            eng_msg   <= req_msg[win_idx];
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          counter <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          counter <= counter + 16'd1;
          if (eng_done) begin
            resp_valid  <= req_onehot(owner);
            resp_result <= eng_result;
            state       <= RESP;
          end else if (counter == TIMEOUT_LAST) begin
            resp_valid <= req_onehot(owner);
            resp_error <= 1'b1;
            eng_abort  <= 1'b1;
            state      <= ABORT;
          end
        end
        RESP, ABORT: begin
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_engine_arbiter.sv
// Table-driven bench for the ECDSA engine arbiter with a response scoreboard.
module tb_ecdsa_engine_arbiter;
  import elliptic_curve_structs::*;

  localparam int TB_TIMEOUT = 12;
  localparam int ABORT_OFS  = TB_TIMEOUT + 2;

  logic             clk;
  logic             master_reset;
  logic [1:0]       req_valid;
  logic [1:0][255:0] req_msg;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  signature_t       resp_result;
  logic             resp_error;
  logic             eng_start;
  logic [255:0]     eng_msg;
  logic             eng_done;
  signature_t       eng_result;
  logic             eng_abort;
  logic             busy;

  ecdsa_engine_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk          (clk),
    .master_reset (master_reset),
    .req_valid    (req_valid),
    .req_msg      (req_msg),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .resp_error   (resp_error),
    .eng_start    (eng_start),
    .eng_msg      (eng_msg),
    .eng_done     (eng_done),
    .eng_result   (eng_result),
    .eng_abort    (eng_abort),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]   req;
    logic [1:0]   hold;
    logic [255:0] msg0;
    logic [255:0] msg1;
    int           done_at;
    logic         spur;
    signature_t   result;
    logic [1:0]   exp_grant;
  } vec_t;

  typedef struct {
    logic [1:0] valid;
    logic       err;
    signature_t res;
    int         at;
  } resp_t;

  resp_t exp_q[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  signature_t junk;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock and compare any response against the scoreboard head.
  task automatic step();
    resp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_valid != 2'b00 || eng_abort) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=%b eng_abort=%b, required none (cycle %0d)",
                 resp_valid, eng_abort, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("resp_valid", 512'(resp_valid), 512'(e.valid));
        checkOutput("resp_error", 512'(resp_error), 512'(e.err));
        checkOutput("eng_abort", 512'(eng_abort), 512'(e.err));
        checkOutput("resp_result", 512'(resp_result), 512'(e.res));
        checkOutput("resp_cycle", 512'(cyc), 512'(e.at));
      end
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] hold,
                              input logic [255:0] m0, input logic [255:0] m1,
                              input int done_at, input logic spur,
                              input logic [1:0] g, input int tag);
    vec_t v;
    v.req       = req;
    v.hold      = hold;
    v.msg0      = m0;
    v.msg1      = m1;
    v.done_at   = done_at;
    v.spur      = spur;
    v.exp_grant = g;
    v.result.r  = 256'hA000 + 256'(tag);
    v.result.s  = ~(256'hB000 + 256'(tag));
    return v;
  endfunction

  // Run one transaction from an idle cycle through to the following idle cycle.
  task automatic applyStimulus(input vec_t v);
    resp_t        e;
    int           acc;
    int           resp_ofs;
    bit           normal;
    logic [255:0] wmsg;
    normal   = (v.done_at >= 2) && (v.done_at <= TB_TIMEOUT + 1);
    resp_ofs = normal ? v.done_at + 1 : ABORT_OFS;
    req_valid  = v.req;
    req_msg[0] = v.msg0;
    req_msg[1] = v.msg1;
    eng_done   = v.spur;
    eng_result = junk;
    #1;
    checkOutput("req_ready", 512'(req_ready), 512'(v.exp_grant));
    acc  = cyc;
    wmsg = v.exp_grant[1] ? v.msg1 : v.msg0;
    e.valid = v.exp_grant;
    e.err   = !normal;
    e.res   = normal ? v.result : '0;
    e.at    = acc + resp_ofs;
    exp_q.push_back(e);
    for (int k = 1; k <= resp_ofs; k++) begin
      step();
      req_valid  = v.hold;
      eng_done   = (k == v.done_at) || (v.spur && k == 1);
      eng_result = (k == v.done_at) ? v.result : junk;
      #1;
      checkOutput("req_ready_busy", 512'(req_ready), 512'(0));
      if (k == 1) begin
        checkOutput("eng_start", 512'(eng_start), 512'(1));
        checkOutput("eng_msg", 512'(eng_msg), 512'(wmsg));
        checkOutput("busy", 512'(busy), 512'(1));
      end else if (k == 2) begin
        checkOutput("eng_start_pulse", 512'(eng_start), 512'(0));
      end
    end
    step();
    eng_done  = 1'b0;
    req_valid = 2'b00;
    checkOutput("busy_idle", 512'(busy), 512'(0));
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missing_resp: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    junk         = '1;
    master_reset = 1'b1;
    req_valid    = 2'b11;
    req_msg[0]   = 256'h55;
    req_msg[1]   = 256'h66;
    eng_done     = 1'b0;
    eng_result   = '0;

    // Reset state with requests pending.
    step();
    step();
    checkOutput("rst_req_ready", 512'(req_ready), 512'(0));
    checkOutput("rst_resp_valid", 512'(resp_valid), 512'(0));
    checkOutput("rst_resp_result", 512'(resp_result), 512'(0));
    checkOutput("rst_resp_error", 512'(resp_error), 512'(0));
    checkOutput("rst_eng_start", 512'(eng_start), 512'(0));
    checkOutput("rst_eng_msg", 512'(eng_msg), 512'(0));
    checkOutput("rst_eng_abort", 512'(eng_abort), 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(0));
    master_reset = 1'b0;
    req_valid    = 2'b00;
    step();

    // Held double request alternates starting with the signer.
    vecs.push_back(mk(2'b11, 2'b11, 256'h11, 256'h22, 3, 1'b0, 2'b01, 1));
    vecs.push_back(mk(2'b11, 2'b11, 256'h11, 256'h22, 3, 1'b0, 2'b10, 2));
    vecs.push_back(mk(2'b11, 2'b00, 256'h11, 256'h22, 3, 1'b0, 2'b01, 3));
    // Signer alone, engine answers ten cycles after acceptance.
    vecs.push_back(mk(2'b01, 2'b00, 256'h1234, 256'h9999, 10, 1'b0, 2'b01, 4));
    // Ties after that follow the previous owner; fastest turnaround back to back.
    vecs.push_back(mk(2'b11, 2'b00, 256'h31, 256'h32, 3, 1'b0, 2'b10, 5));
    vecs.push_back(mk(2'b11, 2'b00, 256'h41, 256'h42, 2, 1'b0, 2'b01, 6));
    vecs.push_back(mk(2'b11, 2'b00, 256'h51, 256'h52, 2, 1'b0, 2'b10, 7));
    // Verifier times out while the signer waits.
    vecs.push_back(mk(2'b10, 2'b01, 256'h61, 256'h62, -1, 1'b0, 2'b10, 8));
    // Completion on the final count cycle is a normal response.
    vecs.push_back(mk(2'b10, 2'b00, 256'h71, 256'h72, TB_TIMEOUT + 1, 1'b0, 2'b10, 9));
    // Completion one cycle too late lands in the abort cycle and is ignored.
    vecs.push_back(mk(2'b01, 2'b00, 256'h81, 256'h82, TB_TIMEOUT + 2, 1'b0, 2'b01, 10));
    // Spurious completions in the accept and start cycles are ignored.
    vecs.push_back(mk(2'b11, 2'b00, 256'h91, 256'h92, 5, 1'b1, 2'b10, 11));
    vecs.push_back(mk(2'b01, 2'b11, 256'hA1, 256'hA2, 4, 1'b0, 2'b01, 12));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while the engine is working drops the request silently.
    req_valid  = 2'b01;
    req_msg[0] = 256'hDEAD;
    #1;
    checkOutput("mid_accept", 512'(req_ready), 512'(2'b01));
    step();
    req_valid = 2'b00;
    step();
    step();
    step();
    master_reset = 1'b1;
    req_valid    = 2'b11;
    step();
    checkOutput("mid_rst_busy", 512'(busy), 512'(0));
    checkOutput("mid_rst_resp", 512'(resp_valid), 512'(0));
    checkOutput("mid_rst_abort", 512'(eng_abort), 512'(0));
    checkOutput("mid_rst_msg", 512'(eng_msg), 512'(0));
    checkOutput("mid_rst_ready", 512'(req_ready), 512'(0));
    master_reset = 1'b0;
    req_valid    = 2'b00;
    for (int i = 0; i < TB_TIMEOUT + 4; i++) step();
    applyStimulus(mk(2'b11, 2'b00, 256'hC1, 256'hC2, 3, 1'b0, 2'b01, 13));
    applyStimulus(mk(2'b11, 2'b00, 256'hD1, 256'hD2, 6, 1'b0, 2'b10, 14));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecdsa_engine_arbiter.md
ECDSA_ENGINE_ARBITER -- requirements
Module: ecdsa_engine_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max cycles waited for eng_done before abort (range 2..65535).
REQ-002 SHALL have port clk, input, 1, sole clock, all logic on posedge.
REQ-003 SHALL have port master_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 2, per-requester request (bit0 = signer, bit1 = verifier).
REQ-005 SHALL have port req_msg, input, 2x256, per-requester message hash, sampled on acceptance.
REQ-006 SHALL have port req_ready, output, 2, one-hot acceptance pulse, combinational from state and req_valid.
REQ-007 SHALL have port resp_valid, output, 2, one-hot one-cycle response pulse to the owning requester.
REQ-008 SHALL have port resp_result, output, signature_t, engine result, zero on error.
REQ-009 SHALL have port resp_error, output, 1, qualifies resp_valid; 1 = timeout abort.
REQ-010 SHALL have port eng_start, output, 1, one-cycle start pulse to the shared ECDSA engine.
REQ-011 SHALL have port eng_msg, output, 256, latched hash driven to the engine, stable from eng_start until response.
REQ-012 SHALL have port eng_done, input, 1, engine completion strobe.
REQ-013 SHALL have port eng_result, input, signature_t, valid when eng_done=1.
REQ-014 SHALL have port eng_abort, output, 1, one-cycle engine reset pulse on timeout.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, START, BUSY, RESP, ABORT.
REQ-017 IDLE: if any req_valid, SHALL assert req_ready[w] for winner w, latch req_msg[w] and owner=w, go START; else stay.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting, winner is the index not equal to last_grant.
REQ-019 START: SHALL assert eng_start for exactly one cycle, clear the timeout counter, go BUSY.
REQ-020 BUSY: SHALL increment the 16-bit counter each cycle; eng_done=1 latches eng_result, goes RESP; else counter==TIMEOUT_CYCLES-1 goes ABORT.
REQ-021 eng_done and timeout in the same cycle: SHALL take eng_done (RESP).
REQ-022 eng_done outside BUSY SHALL be ignored.
REQ-023 RESP: SHALL assert resp_valid[owner]=1, resp_error=0, resp_result=latched result, set last_grant=owner, go IDLE.
REQ-024 ABORT: SHALL assert eng_abort=1, resp_valid[owner]=1, resp_error=1, resp_result=0, set last_grant=owner, go IDLE.
REQ-025 Latency: accept at cycle 0, eng_start at cycle 1, eng_done at cycle k, resp_valid at cycle k+1.
REQ-026 req_ready SHALL be 0 in all states except IDLE; requests held during busy wait without loss.
REQ-027 Minimum gap between consecutive acceptances SHALL be 4 cycles (IDLE->START->BUSY->RESP->IDLE).

Reset
REQ-028 master_reset SHALL force IDLE, last_grant=1 (signer wins first tie), owner=0, counter=0, latched msg/result=0.
REQ-029 During and after reset all outputs SHALL be 0 (req_ready, resp_valid, resp_result, resp_error, eng_start, eng_msg, eng_abort, busy).
REQ-030 Reset mid-operation SHALL drop the in-flight request with no response and no eng_abort pulse.

Structure
REQ-031 signature_t and new constant ECDSA_NUM_REQ=2 SHALL live in package elliptic_curve_structs; state enum stays local.
REQ-032 Round-robin selection SHALL be a sub-module ecdsa_rr_picker (inputs req, last_grant; output one-hot grant).

Verification
REQ-033 req_valid=01, msg=0x1234, eng_done at cycle 10 with result r -> req_ready=01 cycle 0, eng_start cycle 1, eng_msg=0x1234, resp_valid=01 cycle 11, resp_result=r, resp_error=0.
REQ-034 req_valid=11 held after reset -> grants in order 01,10,01 across three transactions.
REQ-035 TIMEOUT_CYCLES=8, no eng_done -> eng_abort and resp_valid with resp_error=1, resp_result=0 at cycle 10.
REQ-036 TIMEOUT_CYCLES=8, eng_done on the final count cycle -> normal RESP, eng_abort never asserted.
REQ-037 master_reset asserted in BUSY -> next cycle busy=0, no resp_valid, no eng_abort; new request accepted afterwards.
REQ-038 Spurious eng_done in IDLE and START -> no resp_valid, state sequence unchanged.
